// File: rtl/mano_bus_encoder.sv
// Registered 8-to-3 common-bus source encoder with conflict detection and a latched fault state.
// Latency 1 cycle; hold freezes outputs; conflict_cnt is built only with MANO_BUS_ENC_CONFLICT_CNT_EN.
// Backpressure: none; hold stalls sampling, FAULT parks the bus until clr_err.
module mano_bus_encoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       sel_in,
  input  logic             hold,
  input  logic             clr_err,
  output logic [2:0]       bus_sel,
  output logic             bus_valid,
  output logic             conflict,
  output logic             err_sticky,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic {
    NORMAL = 1'b0,
    FAULT  = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] bus_sel_nxt;
  logic       bus_valid_nxt;
  logic       conflict_nxt;
  logic       err_nxt;
  logic [2:0] src_count;
  logic [2:0] src_idx;

  // Bit 0 is the explicit "no source" request and never reaches any output.
  logic unused_sel0;
  assign unused_sel0 = sel_in[0];

  always_comb begin
    src_count = 3'd0;
    src_idx   = 3'd0;
    for (int i = 1; i < 8; i++) begin
      src_count = src_count + {2'b00, sel_in[i]};
      if (sel_in[i]) src_idx = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= NORMAL;
      bus_sel    <= 3'd0;
      bus_valid  <= 1'b0;
      conflict   <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state      <= state_nxt;
      bus_sel    <= bus_sel_nxt;
      bus_valid  <= bus_valid_nxt;
      conflict   <= conflict_nxt;
      err_sticky <= err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus_sel_nxt   = bus_sel;
    bus_valid_nxt = bus_valid;
    conflict_nxt  = 1'b0;
    err_nxt       = err_sticky;
    case (state)
      NORMAL: begin
        if (clr_err) err_nxt = 1'b0;
        if (!hold) begin
          if (src_count == 3'd0) begin
            bus_sel_nxt   = 3'd0;
            bus_valid_nxt = 1'b0;
          end else if (src_count == 3'd1) begin
            bus_sel_nxt   = src_idx;
            bus_valid_nxt = 1'b1;
          end else begin
            // Park the bus instead of letting any requester win.
            bus_sel_nxt   = 3'd0;
            bus_valid_nxt = 1'b0;
            conflict_nxt  = 1'b1;
            err_nxt       = 1'b1;
            state_nxt     = FAULT;
          end
        end
      end
      FAULT: begin
        bus_sel_nxt   = 3'd0;
        bus_valid_nxt = 1'b0;
        err_nxt       = 1'b1;
        if (clr_err) begin
          state_nxt = NORMAL;
          err_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt     = NORMAL;
        bus_sel_nxt   = 3'd0;
        bus_valid_nxt = 1'b0;
      end
    endcase
  end

`ifdef MANO_BUS_ENC_CONFLICT_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (conflict_nxt && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign conflict_cnt = cnt_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: doc/mano_bus_encoder.md
# mano_bus_encoder

Registered 8-to-3 bus-source encoder for the Mano basic computer datapath. It converts the one-hot register-to-bus load requests from control logic into the 3-bit common-bus select S2S1S0. It is the inverse of the 3x8 and 4x16 decoders that generate the D and T control lines. It detects multi-source conflicts and latches into a fault state that parks the bus until software or the test bench clears it.

## Interface
- CNT_W, 8, width of the conflict event counter (legal range 1-16)

- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- sel_in  in  8  bus source requests; bit i requests source i (1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 memory); bit 0 means explicit "no source" and is ignored for encoding
- hold  in  1  freeze encoder outputs; no sampling of sel_in
- clr_err  in  1  clear fault state and the err_sticky flag
- bus_sel  out  3  registered bus select S2S1S0
- bus_valid  out  1  registered; 1 when bus_sel names a real source
- conflict  out  1  one-cycle pulse; more than one bit of sel_in[7:1] was sampled high
- err_sticky  out  1  set on any conflict, held until clr_err
- conflict_cnt  out  CNT_W  saturating count of conflict events

## Operation
- FSM with two states: NORMAL and FAULT. Reset state is NORMAL.
- Reset values: bus_sel=0, bus_valid=0, conflict=0, err_sticky=0, conflict_cnt=0.
- Sampling happens in NORMAL with hold=0. Let n be the popcount of sel_in[7:1].
  - n=0: bus_sel<=0, bus_valid<=0.
  - n=1: bus_sel<=index of the set bit, bus_valid<=1.
  - n>=2: bus_sel<=0, bus_valid<=0, conflict<=1 for one cycle, err_sticky<=1, next state FAULT. The bus is parked rather than driven by any priority winner.
- NORMAL with hold=1: bus_sel and bus_valid keep their values. No conflict check is made. conflict<=0.
- FAULT state:
  - bus_sel=0 and bus_valid=0 regardless of sel_in or hold.
  - conflict<=0.
  - err_sticky stays 1.
- clr_err:
  - In FAULT: next state NORMAL, err_sticky<=0. Outputs stay 0 on that edge. Sampling resumes on the following edge.
  - In NORMAL: clears err_sticky. If a conflict is sampled on the same edge, the conflict wins and err_sticky<=1.
- conflict_cnt increments by 1 on each conflict pulse and saturates at 2^CNT_W-1. It is cleared only by reset.
- sel_in[0] never affects any output.

## Timing
- Latency is 1 cycle: sel_in sampled at edge k appears on bus_sel and bus_valid after edge k.
- conflict is high for exactly the cycle following the sampling edge.
- FAULT entry and exit each take effect at one clock edge. The minimum fault duration is 1 cycle when clr_err is already high on the first FAULT edge.
- Assertion of rst_n low immediately (asynchronously) forces all outputs to reset values and the state to NORMAL. This applies mid-fault and mid-hold.
- Deassertion of rst_n is synchronised externally. The block's first sample happens on the first rising edge with rst_n high.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: MANO_BUS_ENC_CONFLICT_CNT_EN.
- Defined: conflict_cnt is implemented as described under Operation.
- Undefined: the counter register is not built and conflict_cnt is tied to 0. The port stays present and all other behaviour is identical.

## Test plan
- Reset and single source:
  - rst_n=0: all outputs 0.
  - Release rst_n, then sel_in=8'b0001_0000 for one edge: bus_sel=3'd4 and bus_valid=1 on the next cycle, conflict=0.
- Sweep and idle:
  - Drive each single bit 1..7: bus_sel equals the bit index with 1-cycle latency.
  - sel_in=8'h01 or 8'h00: bus_sel=0, bus_valid=0.
- Conflict entry:
  - sel_in=8'b1000_0100: next cycle bus_sel=0, bus_valid=0, conflict=1 for 1 cycle, err_sticky=1, conflict_cnt=1 (macro on).
  - Then sel_in=8'h02 with no clr_err: outputs stay 0.
- Fault clear:
  - In FAULT, pulse clr_err with sel_in=8'h08: err_sticky=0 and bus_valid still 0 after that edge.
  - Next edge: bus_sel=3, bus_valid=1.
- Hold:
  - Load 8'h20 (bus_sel=5), then hold=1 with sel_in=8'h06: bus_sel stays 5 and conflict stays 0.
  - Drop hold: conflict pulses and the block enters FAULT.
- Saturation and async reset:
  - With CNT_W=2 and the macro on, force 5 conflict/clear cycles: conflict_cnt stops at 3.
  - Assert rst_n low between clock edges: outputs clear immediately, without waiting for an edge.
